// File: rtl/tennis_match_scorer_if.sv
// Scoreboard bus for the tennis match scorer.
// Point strobes in, score, pulse and winner outputs back.
interface tennis_match_scorer_if #(
  parameter int GW = 5
);
  logic          pl1;
  logic          pl2;
  logic          new_match;
  logic [4:0]    p1_pts;
  logic [4:0]    p2_pts;
  logic [GW-1:0] p1_games;
  logic [GW-1:0] p2_games;
  logic [2:0]    p1_sets;
  logic [2:0]    p2_sets;
  logic          tiebreak;
  logic [1:0]    game_won;
  logic [1:0]    set_won;
  logic          p1_win;
  logic          p2_win;

  modport master (
    output pl1, pl2, new_match,
    input  p1_pts, p2_pts, p1_games, p2_games,
    input  p1_sets, p2_sets, tiebreak,
    input  game_won, set_won, p1_win, p2_win
  );

  modport slave (
    input  pl1, pl2, new_match,
    output p1_pts, p2_pts, p1_games, p2_games,
    output p1_sets, p2_sets, tiebreak,
    output game_won, set_won, p1_win, p2_win
  );
endinterface

// File: rtl/tennis_match_scorer.sv
// Two-player tennis match scorer: points, games, sets, winner.
// Every point resolves game/set/match in a single clock edge.
module tennis_match_scorer #(
  parameter int GAMES_TO_WIN = 6,
  parameter int SETS_TO_WIN  = 2,
  parameter int NO_AD        = 0,
  parameter int TIEBREAK_EN  = 1,
  parameter int TB_POINTS    = 7,
  parameter int GW           = 5
) (
  input  logic clk,
  input  logic rst,
  tennis_match_scorer_if.slave bus
);

  localparam logic [1:0] S_PLAY = 2'd0;
  localparam logic [1:0] S_TB   = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam int GCAP = (1 << GW) - 2;

  localparam logic [5:0]  L_TBP  = TB_POINTS[5:0];
  localparam logic [GW:0] L_GTW  = GAMES_TO_WIN[GW:0];
  localparam logic [GW:0] L_GCAP = GCAP[GW:0];
  localparam logic [GW:0] L_GONE = 1;
  localparam logic [GW:0] L_GTWO = 2;
  localparam logic [2:0]  L_STW  = SETS_TO_WIN[2:0];

  logic [1:0]    r_state;
  logic [4:0]    r_p1_pts;
  logic [4:0]    r_p2_pts;
  logic [GW-1:0] r_p1_games;
  logic [GW-1:0] r_p2_games;
  logic [2:0]    r_p1_sets;
  logic [2:0]    r_p2_sets;
  logic          r_tiebreak;
  logic [1:0]    r_game_won;
  logic [1:0]    r_set_won;
  logic          r_p1_win;
  logic          r_p2_win;

  logic [1:0]    w_state;
  logic [4:0]    w_p1_pts;
  logic [4:0]    w_p2_pts;
  logic [GW-1:0] w_p1_games;
  logic [GW-1:0] w_p2_games;
  logic [2:0]    w_p1_sets;
  logic [2:0]    w_p2_sets;
  logic          w_tiebreak;
  logic [1:0]    w_game_won;
  logic [1:0]    w_set_won;
  logic          w_p1_win;
  logic          w_p2_win;

  logic w_p1;
  logic w_p2;
  logic w_go;

  // Scores are handled as winner (x) / loser (y) and mapped back.
  logic [5:0]  w_xp;
  logic [5:0]  w_yp;
  logic [GW:0] w_xg;
  logic [GW:0] w_yg;
  logic [2:0]  w_xs;
  logic        w_gw;
  logic        w_sw;
  logic        w_tb;
  logic        w_over;

  assign w_p1 = bus.pl1 & ~bus.pl2;
  assign w_p2 = bus.pl2 & ~bus.pl1;
  assign w_go = (w_p1 | w_p2) & (r_state != S_OVER);

  // Next-state scoring for one point, or match restart.
  always_comb begin
    w_state    = r_state;
    w_p1_pts   = r_p1_pts;
    w_p2_pts   = r_p2_pts;
    w_p1_games = r_p1_games;
    w_p2_games = r_p2_games;
    w_p1_sets  = r_p1_sets;
    w_p2_sets  = r_p2_sets;
    w_tiebreak = r_tiebreak;
    w_game_won = 2'b00;
    w_set_won  = 2'b00;
    w_p1_win   = r_p1_win;
    w_p2_win   = r_p2_win;

    w_xp   = w_p1 ? {1'b0, r_p1_pts} : {1'b0, r_p2_pts};
    w_yp   = w_p1 ? {1'b0, r_p2_pts} : {1'b0, r_p1_pts};
    w_xg   = w_p1 ? {1'b0, r_p1_games} : {1'b0, r_p2_games};
    w_yg   = w_p1 ? {1'b0, r_p2_games} : {1'b0, r_p1_games};
    w_xs   = w_p1 ? r_p1_sets : r_p2_sets;
    w_gw   = 1'b0;
    w_sw   = 1'b0;
    w_tb   = r_tiebreak;
    w_over = 1'b0;

    unique case (1'b1)
      (r_state == S_OVER): begin
        if (bus.new_match) begin
          w_state    = S_PLAY;
          w_p1_pts   = '0;
          w_p2_pts   = '0;
          w_p1_games = '0;
          w_p2_games = '0;
          w_p1_sets  = '0;
          w_p2_sets  = '0;
          w_tiebreak = 1'b0;
          w_p1_win   = 1'b0;
          w_p2_win   = 1'b0;
        end
      end
      (r_state == S_TB): begin
        if (w_go) begin
          w_xp = w_xp + 6'd1;
          if (w_xp >= L_TBP && w_xp >= w_yp + 6'd2) begin
            w_xp = '0;
            w_yp = '0;
            w_gw = 1'b1;
            w_xg = L_GTW + L_GONE;
            w_sw = 1'b1;
          end else if (w_xp == 6'd31 && w_yp == 6'd31) begin
            w_xp = 6'd30;
            w_yp = 6'd30;
          end
        end
      end
      default: begin
        if (w_go) begin
          w_xp = w_xp + 6'd1;
          if ((NO_AD != 0) ? (w_xp == 6'd4)
              : (w_xp >= 6'd4 && w_xp >= w_yp + 6'd2)) begin
            w_xp = '0;
            w_yp = '0;
            w_gw = 1'b1;
            w_xg = w_xg + L_GONE;
            if (w_xg >= L_GTW && w_xg >= w_yg + L_GTWO) begin
              w_sw = 1'b1;
            end else if (TIEBREAK_EN != 0 && w_xg == L_GTW
                         && w_yg == L_GTW) begin
              w_tb    = 1'b1;
              w_state = S_TB;
            end else if (TIEBREAK_EN == 0 && w_xg == L_GCAP
                         && w_yg == L_GCAP) begin
              w_xg = w_xg - L_GONE;
              w_yg = w_yg - L_GONE;
            end
          end else if (w_xp == 6'd4 && w_yp == 6'd4) begin
            w_xp = 6'd3;
            w_yp = 6'd3;
          end
        end
      end
    endcase

    if (w_sw) begin
      w_xs = w_xs + 3'd1;
      w_xp = '0;
      w_yp = '0;
      w_xg = '0;
      w_yg = '0;
      w_tb = 1'b0;
      if (w_xs == L_STW) begin
        w_over  = 1'b1;
        w_state = S_OVER;
      end else begin
        w_state = S_PLAY;
      end
    end

    if (w_go && w_p1) begin
      w_p1_pts   = w_xp[4:0];
      w_p2_pts   = w_yp[4:0];
      w_p1_games = w_xg[GW-1:0];
      w_p2_games = w_yg[GW-1:0];
      w_p1_sets  = w_xs;
      w_tiebreak = w_tb;
      w_game_won = {w_gw, 1'b0};
      w_set_won  = {w_sw, 1'b0};
      w_p1_win   = w_over;
    end else if (w_go) begin
      w_p2_pts   = w_xp[4:0];
      w_p1_pts   = w_yp[4:0];
      w_p2_games = w_xg[GW-1:0];
      w_p1_games = w_yg[GW-1:0];
      w_p2_sets  = w_xs;
      w_tiebreak = w_tb;
      w_game_won = {1'b0, w_gw};
      w_set_won  = {1'b0, w_sw};
      w_p2_win   = w_over;
    end
  end

  // Score registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_PLAY;
      r_p1_pts   <= '0;
      r_p2_pts   <= '0;
      r_p1_games <= '0;
      r_p2_games <= '0;
      r_p1_sets  <= '0;
      r_p2_sets  <= '0;
      r_tiebreak <= 1'b0;
      r_game_won <= 2'b00;
      r_set_won  <= 2'b00;
      r_p1_win   <= 1'b0;
      r_p2_win   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_p1_pts   <= w_p1_pts;
      r_p2_pts   <= w_p2_pts;
      r_p1_games <= w_p1_games;
      r_p2_games <= w_p2_games;
      r_p1_sets  <= w_p1_sets;
      r_p2_sets  <= w_p2_sets;
      r_tiebreak <= w_tiebreak;
      r_game_won <= w_game_won;
      r_set_won  <= w_set_won;
      r_p1_win   <= w_p1_win;
      r_p2_win   <= w_p2_win;
    end
  end

  assign bus.p1_pts   = r_p1_pts;
  assign bus.p2_pts   = r_p2_pts;
  assign bus.p1_games = r_p1_games;
  assign bus.p2_games = r_p2_games;
  assign bus.p1_sets  = r_p1_sets;
  assign bus.p2_sets  = r_p2_sets;
  assign bus.tiebreak = r_tiebreak;
  assign bus.game_won = r_game_won;
  assign bus.set_won  = r_set_won;
  assign bus.p1_win   = r_p1_win;
  assign bus.p2_win   = r_p2_win;

endmodule

// File: tb/tb_tennis_match_scorer.sv
// Bench for tennis_match_scorer: two configurations checked
// against a plain-integer model of the tennis rules.
module tb_tennis_match_scorer;

  localparam int GW  = 5;
  localparam int TBP = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  tennis_match_scorer_if #(.GW(GW)) bus0 ();
  tennis_match_scorer_if #(.GW(GW)) bus1 ();

  tennis_match_scorer #(
    .GAMES_TO_WIN(6), .SETS_TO_WIN(2), .NO_AD(0),
    .TIEBREAK_EN(1), .TB_POINTS(TBP), .GW(GW)
  ) u0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  tennis_match_scorer #(
    .GAMES_TO_WIN(2), .SETS_TO_WIN(3), .NO_AD(1),
    .TIEBREAK_EN(0), .TB_POINTS(TBP), .GW(GW)
  ) u1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  function automatic int gtw(int k);
    return (k == 0) ? 6 : 2;
  endfunction
  function automatic int stw(int k);
    return (k == 0) ? 2 : 3;
  endfunction
  function automatic bit noad(int k);
    return k != 0;
  endfunction
  function automatic bit tben(int k);
    return k == 0;
  endfunction

  int n_vec = 0;
  int n_err = 0;

  int m_pts[2][2];
  int m_g[2][2];
  int m_s[2][2];
  int m_win[2][2];
  bit m_tb[2];
  bit m_over[2];
  int m_gw[2];
  int m_sw[2];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear(int k);
    for (int p = 0; p < 2; p++) begin
      m_pts[k][p] = 0;
      m_g[k][p]   = 0;
      m_s[k][p]   = 0;
      m_win[k][p] = 0;
    end
    m_tb[k]   = 0;
    m_over[k] = 0;
    m_gw[k]   = 0;
    m_sw[k]   = 0;
  endtask

  task automatic take_set(int k, int x);
    m_sw[k] = (x == 0) ? 2 : 1;
    m_s[k][x] += 1;
    m_g[k][0] = 0;
    m_g[k][1] = 0;
    m_pts[k][0] = 0;
    m_pts[k][1] = 0;
    m_tb[k] = 0;
    if (m_s[k][x] == stw(k)) begin
      m_over[k] = 1;
      m_win[k][x] = 1;
    end
  endtask

  task automatic model_step(int k, bit a, bit b, bit nm);
    int x;
    int y;
    bit won;
    m_gw[k] = 0;
    m_sw[k] = 0;
    if (m_over[k]) begin
      if (nm) model_clear(k);
      return;
    end
    if (a == b) return;
    x = a ? 0 : 1;
    y = 1 - x;
    m_pts[k][x] += 1;
    if (m_tb[k]) begin
      if (m_pts[k][x] >= TBP && m_pts[k][x] - m_pts[k][y] >= 2) begin
        m_pts[k][0] = 0;
        m_pts[k][1] = 0;
        m_gw[k] = (x == 0) ? 2 : 1;
        m_g[k][x] = gtw(k) + 1;
        take_set(k, x);
      end else if (m_pts[k][0] == 31 && m_pts[k][1] == 31) begin
        m_pts[k][0] = 30;
        m_pts[k][1] = 30;
      end
      return;
    end
    if (noad(k)) won = (m_pts[k][x] == 4);
    else won = (m_pts[k][x] >= 4) && (m_pts[k][x] - m_pts[k][y] >= 2);
    if (won) begin
      m_pts[k][0] = 0;
      m_pts[k][1] = 0;
      m_gw[k] = (x == 0) ? 2 : 1;
      m_g[k][x] += 1;
      if (m_g[k][x] >= gtw(k) && m_g[k][x] - m_g[k][y] >= 2) begin
        take_set(k, x);
      end else if (tben(k) && m_g[k][0] == gtw(k) && m_g[k][1] == gtw(k)) begin
        m_tb[k] = 1;
      end else if (!tben(k) && m_g[k][0] == (1 << GW) - 2
                   && m_g[k][1] == (1 << GW) - 2) begin
        m_g[k][0] -= 1;
        m_g[k][1] -= 1;
      end
    end else if (m_pts[k][0] == 4 && m_pts[k][1] == 4) begin
      m_pts[k][0] = 3;
      m_pts[k][1] = 3;
    end
  endtask

  task automatic check_all(int k);
    logic [4:0]    op1, op2;
    logic [GW-1:0] og1, og2;
    logic [2:0]    os1, os2;
    logic          otb, ow1, ow2;
    logic [1:0]    ogw, osw;
    if (k == 0) begin
      op1 = bus0.p1_pts;   op2 = bus0.p2_pts;
      og1 = bus0.p1_games; og2 = bus0.p2_games;
      os1 = bus0.p1_sets;  os2 = bus0.p2_sets;
      otb = bus0.tiebreak; ogw = bus0.game_won;
      osw = bus0.set_won;  ow1 = bus0.p1_win;
      ow2 = bus0.p2_win;
    end else begin
      op1 = bus1.p1_pts;   op2 = bus1.p2_pts;
      og1 = bus1.p1_games; og2 = bus1.p2_games;
      os1 = bus1.p1_sets;  os2 = bus1.p2_sets;
      otb = bus1.tiebreak; ogw = bus1.game_won;
      osw = bus1.set_won;  ow1 = bus1.p1_win;
      ow2 = bus1.p2_win;
    end
    check($sformatf("u%0d.p1_pts", k), 32'(op1), m_pts[k][0]);
    check($sformatf("u%0d.p2_pts", k), 32'(op2), m_pts[k][1]);
    check($sformatf("u%0d.p1_games", k), 32'(og1), m_g[k][0]);
    check($sformatf("u%0d.p2_games", k), 32'(og2), m_g[k][1]);
    check($sformatf("u%0d.p1_sets", k), 32'(os1), m_s[k][0]);
    check($sformatf("u%0d.p2_sets", k), 32'(os2), m_s[k][1]);
    check($sformatf("u%0d.tiebreak", k), 32'(otb), 32'(m_tb[k]));
    check($sformatf("u%0d.game_won", k), 32'(ogw), m_gw[k]);
    check($sformatf("u%0d.set_won", k), 32'(osw), m_sw[k]);
    check($sformatf("u%0d.p1_win", k), 32'(ow1), m_win[k][0]);
    check($sformatf("u%0d.p2_win", k), 32'(ow2), m_win[k][1]);
  endtask

  task automatic step(bit a0, bit b0, bit n0, bit a1, bit b1, bit n1);
    @(negedge clk);
    bus0.pl1 = a0; bus0.pl2 = b0; bus0.new_match = n0;
    bus1.pl1 = a1; bus1.pl2 = b1; bus1.new_match = n1;
    @(posedge clk);
    #1;
    bus0.pl1 = 0; bus0.pl2 = 0; bus0.new_match = 0;
    bus1.pl1 = 0; bus1.pl2 = 0; bus1.new_match = 0;
    model_step(0, a0, b0, n0);
    model_step(1, a1, b1, n1);
    check_all(0);
    check_all(1);
  endtask

  task automatic pt(int k, int p);
    if (k == 0) step(p == 0, p == 1, 0, 0, 0, 0);
    else step(0, 0, 0, p == 0, p == 1, 0);
  endtask

  task automatic game(int k, int p);
    for (int i = 0; i < 4; i++) pt(k, p);
  endtask

  // Async reset asserted between edges, checked before any edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_clear(0);
    model_clear(1);
    check_all(0);
    check_all(1);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int bias[2];
    bit a[2], b[2], nm[2];
    bus0.pl1 = 0; bus0.pl2 = 0; bus0.new_match = 0;
    bus1.pl1 = 0; bus1.pl2 = 0; bus1.new_match = 0;
    model_clear(0);
    model_clear(1);
    #12;
    check_all(0);
    check_all(1);
    @(negedge clk);
    rst = 1'b1;

    game(0, 0);
    step(0, 0, 1, 0, 0, 1);

    do_reset();
    pt(0, 0); pt(0, 0); pt(0, 1);
    step(1, 1, 0, 1, 1, 0);

    do_reset();
    for (int i = 0; i < 3; i++) begin
      pt(0, 0); pt(0, 1); pt(1, 0); pt(1, 1);
    end
    pt(0, 0); pt(0, 1); pt(0, 1); pt(0, 1);
    pt(1, 1);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      game(0, 0); game(0, 1);
    end
    for (int i = 0; i < 5; i++) begin
      pt(0, 0); pt(0, 1);
    end
    pt(0, 0); pt(0, 0);
    for (int i = 0; i < 6; i++) game(0, 0);
    pt(0, 0); pt(0, 1);
    step(0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      game(0, 0); game(0, 1);
    end
    pt(0, 0); pt(0, 1); pt(0, 0);
    do_reset();

    for (int i = 0; i < 35; i++) begin
      game(1, 0); game(1, 1);
    end

    do_reset();
    bias[0] = 50;
    bias[1] = 50;
    for (int n = 0; n < 4000; n++) begin
      for (int k = 0; k < 2; k++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 3) begin
          a[k] = 1; b[k] = 1;
        end else if (r < 6) begin
          a[k] = 0; b[k] = 0;
        end else begin
          a[k] = $urandom_range(0, 99) < bias[k];
          b[k] = !a[k];
        end
        nm[k] = ($urandom_range(0, 24) == 0);
        if (nm[k]) bias[k] = $urandom_range(30, 70);
      end
      step(a[0], b[0], nm[0], a[1], b[1], nm[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
